// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper for 4-input function blocks: drives all 16 vectors,
// samples f_in after a settle time and packs the results into a minterm word.
module tt_sweep_capture #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] minterms,
    output logic [4:0]  ones_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_d;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] vec;

    assign {a, b, c, d} = vec;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (idx == 4'hF) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            vec        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            minterms   <= 16'h0000;
            ones_count <= 5'd0;
        end else begin
            state <= state_d;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        vec        <= 4'd0;
                        busy       <= 1'b1;
                        minterms   <= 16'h0000;
                        ones_count <= 5'd0;
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + 4'd1;
                SAMPLE: begin
                    minterms[idx] <= f_in;
                    ones_count    <= ones_count + {4'd0, f_in};
                    // Last vector: release the bus and flag completion together
                    if (idx == 4'hF) begin
                        busy <= 1'b0;
                        vec  <= 4'd0;
                        done <= 1'b1;
                    end else begin
                        idx        <= idx + 4'd1;
                        vec        <= idx + 4'd1;
                        settle_cnt <= 4'd0;
                    end
                end
                DONE:    done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: two instances (default settle and
// SETTLE_CYCLES=1), each fed by a small function-block model.
module tb_tt_sweep_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    int   mode = 0;
    int   vectors = 0;
    int   errors = 0;

    logic        a0, b0, c0, d0, f0, busy0, done0;
    logic [15:0] min0;
    logic [4:0]  ones0;
    logic        a1, b1, c1, d1, f1, busy1, done1;
    logic [15:0] min1;
    logic [4:0]  ones1;
    logic        st0, st1;

    always #5 clk = ~clk;

    assign st0 = start & ~sel;
    assign st1 = start & sel;

    always_comb begin
        f0 = 1'b0;
        if (mode == 1) f0 = a0 ^ b0 ^ c0 ^ d0;
        else if (mode == 2) f0 = 1'b1;
    end
    assign f1 = a1 & d1;

    tt_sweep_capture #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(st0),
        .a(a0), .b(b0), .c(c0), .d(d0), .f_in(f0),
        .busy(busy0), .done(done0),
        .minterms(min0), .ones_count(ones0)
    );

    tt_sweep_capture #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1),
        .a(a1), .b(b1), .c(c1), .d(d1), .f_in(f1),
        .busy(busy1), .done(done1),
        .minterms(min1), .ones_count(ones1)
    );

    logic [3:0]  cur_vec;
    logic        cur_busy, cur_done;
    logic [15:0] cur_min;
    logic [4:0]  cur_ones;

    always_comb begin
        if (sel) begin
            cur_vec  = {a1, b1, c1, d1};
            cur_busy = busy1;
            cur_done = done1;
            cur_min  = min1;
            cur_ones = ones1;
        end else begin
            cur_vec  = {a0, b0, c0, d0};
            cur_busy = busy0;
            cur_done = done0;
            cur_min  = min0;
            cur_ones = ones0;
        end
    end

    // Start a sweep and check every cycle up to one past DONE.
    // pulse_at: cycle index at which start is re-pulsed (-1 for none).
    task automatic sweep(input string name, input int s, input logic [15:0] exp_min,
                         input logic [4:0] exp_ones, input int pulse_at, input logic hold);
        int per, last;
        logic [3:0] ev;
        per  = s + 1;
        last = 16 * per;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk);
            #1;
            start = hold || (k == pulse_at);
            ev = (k < last) ? 4'(k / per) : 4'd0;
            vectors++;
            if (cur_vec !== ev) begin
                errors++;
                $display("FAIL %s vec k=%0d: got %h expected %h", name, k, cur_vec, ev);
            end
            vectors++;
            if (cur_busy !== (k < last)) begin
                errors++;
                $display("FAIL %s busy k=%0d: got %b expected %b", name, k, cur_busy, k < last);
            end
            vectors++;
            if (cur_done !== (k == last)) begin
                errors++;
                $display("FAIL %s done k=%0d: got %b expected %b", name, k, cur_done, k == last);
            end
        end
        vectors++;
        if (cur_min !== exp_min) begin
            errors++;
            $display("FAIL %s minterms: got %h expected %h", name, cur_min, exp_min);
        end
        vectors++;
        if (cur_ones !== exp_ones) begin
            errors++;
            $display("FAIL %s ones_count: got %0d expected %0d", name, cur_ones, exp_ones);
        end
    endtask

    task automatic check_reset_state(input string name);
        vectors++;
        if ({a0, b0, c0, d0, busy0, done0, min0, ones0} !== 27'd0) begin
            errors++;
            $display("FAIL %s dut0: got vec=%b busy=%b done=%b min=%h ones=%0d expected all 0",
                     name, {a0, b0, c0, d0}, busy0, done0, min0, ones0);
        end
        vectors++;
        if ({a1, b1, c1, d1, busy1, done1, min1, ones1} !== 27'd0) begin
            errors++;
            $display("FAIL %s dut1: got vec=%b busy=%b done=%b min=%h ones=%0d expected all 0",
                     name, {a1, b1, c1, d1}, busy1, done1, min1, ones1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
    endtask

    task automatic test_zero();
        sel = 1'b0; mode = 0;
        sweep("zero", 2, 16'h0000, 5'd0, -1, 1'b0);
    endtask

    task automatic test_xor();
        sel = 1'b0; mode = 1;
        sweep("xor", 2, 16'h6996, 5'd8, -1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (min0 !== 16'h6996) begin
            errors++;
            $display("FAIL xor_hold: got %h expected 6996", min0);
        end
    endtask

    task automatic test_ones();
        sel = 1'b0; mode = 2;
        sweep("ones", 2, 16'hFFFF, 5'd16, -1, 1'b0);
    endtask

    task automatic test_restart_ignored();
        sel = 1'b0; mode = 1;
        sweep("restart", 2, 16'h6996, 5'd8, 15, 1'b0);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 22; k++) @(posedge clk);
        #1;
        vectors++;
        if ({a0, b0, c0, d0} !== 4'd7) begin
            errors++;
            $display("FAIL mid_vec: got %h expected 7", {a0, b0, c0, d0});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        rst = 1'b0;
        mode = 1;
        sweep("after_reset", 2, 16'h6996, 5'd8, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; mode = 2;
        sweep("b2b", 2, 16'hFFFF, 5'd16, -1, 1'b1);
        @(posedge clk);
        #1;
        vectors++;
        if (busy0 !== 1'b1 || min0 !== 16'h0000 || ones0 !== 5'd0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b min=%h ones=%0d expected 1 0000 0",
                     busy0, min0, ones0);
        end
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_settle1();
        sel = 1'b1;
        sweep("settle1", 1, 16'hAA00, 5'd4, -1, 1'b0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_xor();
        test_ones();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_settle1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
